// File: rtl/trng_pkg.sv
// Shared defaults and sizing helper for the TRNG entropy collector.
package trng_pkg;
  localparam int ROSC_NUM_DEF      = 32;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int SAMPLE_CYCLES_DEF = 16;
  localparam int RCT_CUTOFF_DEF    = 32;

  // Bits needed to hold 0..value-1; never less than 1 so degenerate counters stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test: flags a sticky failure once RCT_CUTOFF identical samples arrive in a row.
// Failure is registered on the edge of the sample that reaches the cutoff; enable=0 restarts the run count.
module trng_rct
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic tick,
  input  logic sample_bit,
  output logic health_fail
);
  localparam int CW = clog2(RCT_CUTOFF + 1);

  logic [CW-1:0] rct_cnt;
  logic [CW-1:0] cnt_next;
  logic          rct_last;

  // A zero count means no previous sample, so the first bit always starts a run of 1.
  always_comb begin
    cnt_next = CW'(1);
    if (rct_cnt != '0 && sample_bit == rct_last) begin
      cnt_next = (rct_cnt >= CW'(RCT_CUTOFF)) ? rct_cnt : rct_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rct_cnt     <= '0;
      rct_last    <= 1'b0;
      health_fail <= 1'b0;
    end else if (!enable) begin
      rct_cnt <= '0;
    end else if (tick) begin
      rct_cnt  <= cnt_next;
      rct_last <= sample_bit;
      if (cnt_next >= CW'(RCT_CUTOFF)) health_fail <= 1'b1;
    end
  end
endmodule

// File: rtl/trng_rosc_collector.sv
// Ring-oscillator entropy collector: 2-FF sync, XOR-fold per tick, MSB-first word; data_valid rises on the final tick's edge.
// One word held for valid/ack; an overrun word is dropped unless acked that cycle. TRNG_RCT_EN adds the repetition-count test.
module trng_rosc_collector
  import trng_pkg::*;
#(
  parameter int NUM_ROSC      = ROSC_NUM_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
  parameter int RCT_CUTOFF    = RCT_CUTOFF_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_ROSC-1:0]   rosc_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ack,
  output logic                  health_fail
);
  localparam int BW = clog2(DATA_WIDTH);
  localparam int PW = clog2(SAMPLE_CYCLES);

  if (NUM_ROSC < 1 || DATA_WIDTH < 2 || SAMPLE_CYCLES < 1 || RCT_CUTOFF < 2) begin : g_bad_param
    $error("trng_rosc_collector: parameter out of range");
  end

  logic [NUM_ROSC-1:0]   rosc_sync;
  logic [PW-1:0]         pre_cnt;
  logic                  tick;
  logic                  sample_bit;
  logic                  shift;
  logic                  word_done;
  logic [DATA_WIDTH-2:0] shreg;
  logic [BW-1:0]         bitcnt;
  logic [DATA_WIDTH-1:0] new_word;

  for (genvar i = 0; i < NUM_ROSC; i++) begin : g_sync
    logic [1:0] sync_ff;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_ff <= '0;
      else       sync_ff <= {sync_ff[0], rosc_in[i]};
    end
    assign rosc_sync[i] = sync_ff[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                pre_cnt <= '0;
    else if (!enable)                         pre_cnt <= '0;
    else if (pre_cnt == PW'(SAMPLE_CYCLES-1)) pre_cnt <= '0;
    else                                      pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick       = enable && (pre_cnt == PW'(SAMPLE_CYCLES-1));
  assign sample_bit = ^rosc_sync;
  assign shift      = tick && !health_fail;
  assign word_done  = shift && (bitcnt == BW'(DATA_WIDTH-1));
  assign new_word   = {shreg, sample_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (!enable) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (shift) begin
      shreg  <= new_word[DATA_WIDTH-2:0];
      bitcnt <= word_done ? '0 : bitcnt + BW'(1);
    end
  end

  // A completed word only lands when the output slot is free or being freed this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else if (word_done) begin
      if (!data_valid || data_ack) begin
        data       <= new_word;
        data_valid <= 1'b1;
      end
    end else if (data_ack && data_valid) begin
      data_valid <= 1'b0;
    end
  end

`ifdef TRNG_RCT_EN
  trng_rct #(
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .sample_bit  (sample_bit),
    .health_fail (health_fail)
  );
`else
  assign health_fail = 1'b0;
`endif
endmodule

// File: tb/tb_trng_rosc_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_trng_rosc_collector;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int SC  = 4;
  localparam int CUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NR-1:0] rosc_in;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ack;
  logic          health_fail;

  always #5 clk = ~clk;

  trng_rosc_collector #(
    .NUM_ROSC      (NR),
    .DATA_WIDTH    (DW),
    .SAMPLE_CYCLES (SC),
    .RCT_CUTOFF    (CUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rosc_in     (rosc_in),
    .data        (data),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .health_fail (health_fail)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: inputs reach the XOR fold two edges late, one sample every SC enabled cycles.
  logic [NR-1:0] m_in_q[$];
  int            m_en_cycles;
  bit            m_bits[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_hf;
  int            m_run;
  bit            m_last;

  function automatic void model_reset();
    m_in_q.delete();
    m_in_q.push_back('0);
    m_in_q.push_back('0);
    m_en_cycles = 0;
    m_bits.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_hf    = 1'b0;
    m_run   = 0;
    m_last  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit            tk;
    bit            b;
    bit            done;
    logic [DW-1:0] w;
    tk   = enable && ((m_en_cycles % SC) == SC - 1);
    b    = ^m_in_q[0];
    done = 1'b0;
    w    = '0;
    if (!enable) begin
      m_en_cycles = 0;
      m_bits.delete();
    end else begin
      m_en_cycles++;
    end
    if (tk && !m_hf) begin
      m_bits.push_back(b);
      if (m_bits.size() == DW) begin
        foreach (m_bits[i]) w[DW-1-i] = m_bits[i];
        m_bits.delete();
        done = 1'b1;
      end
    end
`ifdef TRNG_RCT_EN
    if (!enable) m_run = 0;
    else if (tk) begin
      if (m_run > 0 && b == m_last) m_run++;
      else m_run = 1;
      m_last = b;
      if (m_run >= CUT) m_hf = 1'b1;
    end
`endif
    if (done) begin
      if (!m_valid || data_ack) begin
        m_data  = w;
        m_valid = 1'b1;
      end
    end else if (data_ack && m_valid) begin
      m_valid = 1'b0;
    end
    void'(m_in_q.pop_front());
    m_in_q.push_back(rosc_in);
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("data", 32'(data), 32'(m_data));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    data_ack = 1'b0;
    rosc_in  = '0;
    #1;
    model_reset();
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_hf", 32'(health_fail), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present r for one full sample period; optionally ack during the tick cycle.
  task automatic do_tick(input logic [NR-1:0] r, input bit ack);
    rosc_in = r;
    cyc();
    cyc();
    cyc();
    data_ack = ack;
    cyc();
    data_ack = 1'b0;
  endtask

  initial begin
    do_reset();
    repeat (100) cyc();
    chk("idle_valid", 32'(data_valid), 32'h0);

    // Basic word 0,1,0,1,... -> 8'h55
    enable = 1'b1;
    for (int i = 0; i < DW; i++) do_tick((i % 2) ? 4'b0111 : 4'b0011, 1'b0);
    chk("basic_data", 32'(data), 32'h55);
    chk("basic_valid", 32'(data_valid), 32'h1);

    // Overrun: an all-ones word arrives while 8'h55 is pending and is dropped
    for (int i = 0; i < DW; i++) do_tick(4'b0001, 1'b0);
    chk("ovr_data", 32'(data), 32'h55);
    chk("ovr_valid", 32'(data_valid), 32'h1);
    do_tick(4'b0011, 1'b1);
    chk("ack_clear", 32'(data_valid), 32'h0);
    for (int i = 1; i < DW; i++) do_tick(4'b0011, 1'b0);
    chk("after_ovr_data", 32'(data), 32'h00);
    chk("after_ovr_valid", 32'(data_valid), 32'h1);

    // Ack in the completion cycle of 8'hAA
    for (int i = 0; i < DW; i++) do_tick((i % 2) ? 4'b0011 : 4'b0111, i == DW - 1);
    chk("simul_data", 32'(data), 32'hAA);
    chk("simul_valid", 32'(data_valid), 32'h1);

    // Enable abort after 3 ticks; pending word and handshake survive
    for (int i = 0; i < 3; i++) do_tick(4'b0111, 1'b0);
    enable = 1'b0;
    repeat (3) cyc();
    chk("abort_data", 32'(data), 32'hAA);
    chk("abort_valid", 32'(data_valid), 32'h1);
    data_ack = 1'b1;
    cyc();
    data_ack = 1'b0;
    chk("abort_ack", 32'(data_valid), 32'h0);
    repeat (2) cyc();
    enable = 1'b1;
    for (int i = 0; i < DW; i++) begin
      do_tick((i % 4 < 2) ? 4'b0111 : 4'b0011, 1'b0);
      if (i == DW - 2) chk("reen_early_valid", 32'(data_valid), 32'h0);
    end
    chk("reen_data", 32'(data), 32'hCC);
    chk("reen_valid", 32'(data_valid), 32'h1);

`ifdef TRNG_RCT_EN
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < CUT - 1; i++) do_tick(4'b0001, 1'b0);
    chk("rct_pre", 32'(health_fail), 32'h0);
    do_tick(4'b0001, 1'b0);
    chk("rct_fail", 32'(health_fail), 32'h1);
    chk("rct_data", 32'(data), 32'hFF);
    data_ack = 1'b1;
    cyc();
    data_ack = 1'b0;
    for (int i = 0; i < 10; i++) do_tick((i % 2) ? 4'b0011 : 4'b0001, 1'b0);
    chk("rct_no_valid", 32'(data_valid), 32'h0);
    chk("rct_sticky", 32'(health_fail), 32'h1);
`endif

    // Random traffic with occasional enable drops and mid-run resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      enable   = ($urandom_range(0, 49) != 0);
      rosc_in  = NR'($urandom);
      data_ack = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
